rst_seq_gen: RTL and testbench



---
 rtl/rst_seq_gen.sv | 177 +++++++++++++++++
 tb/tb_rst_seq_gen.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// Reset sequencer: waits for PLL settle, releases channel resets in
// stages, then serves per-channel software reset pulses.
module rst_seq_gen #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned PLL_WAIT   = 20'h1ffff,
    parameter int unsigned USE_LOCK   = 1,
    parameter int unsigned STAGE_GAP  = 16,
    parameter int unsigned SW_RST_CYC = 8,
    parameter int unsigned DIV_W      = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              pll_lock,
    input  logic [NUM_CH-1:0] sw_rst_req,
    input  logic [DIV_W-1:0]  div_sel,
    output logic [NUM_CH-1:0] rst_out_n,
    output logic [1:0]        seq_state,
    output logic              seq_done,
    output logic              pll_timeout,
    output logic              clk_div_out
);

    localparam int unsigned GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int unsigned CH_W   = $clog2(NUM_CH + 1);
    localparam int unsigned SW_W   = $clog2(SW_RST_CYC + 1);
    localparam int unsigned DCNT_W = 1 << DIV_W;
    localparam bit          LOCK_EN = (USE_LOCK != 0);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PLL_WAIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [SW_W-1:0]  SW_LOAD   = SW_W'(SW_RST_CYC);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_WAIT  = 2'd1,
        ST_REL   = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        rst_sync;
    logic [1:0]        lock_sync;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              tmo_q, tmo_d;
    logic [DCNT_W-1:0] div_q;

    logic [NUM_CH-1:0][SW_W-1:0] sw_q, sw_d;

    logic irst;
    logic lock_s;
    logic lock_ok;
    logic wait_hit;
    logic abort;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rst_sync  <= 2'b11;
            lock_sync <= 2'b00;
        end else begin
            rst_sync  <= {rst_sync[0], 1'b0};
            lock_sync <= {lock_sync[0], pll_lock};
        end
    end

    assign irst     = rst_sync[1];
    assign lock_s   = lock_sync[1];
    assign lock_ok  = LOCK_EN && lock_s;
    assign wait_hit = (wait_q == WAIT_LAST);

    // Lock loss only counts once lock was the reason we left the wait.
    assign abort = LOCK_EN && !tmo_q && !lock_s &&
                   (state_q == ST_REL || state_q == ST_RUN);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_RESET;
            wait_q  <= '0;
            gap_q   <= '0;
            ch_q    <= '0;
            rst_q   <= '0;
            tmo_q   <= 1'b0;
            sw_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            ch_q    <= ch_d;
            rst_q   <= rst_d;
            tmo_q   <= tmo_d;
            sw_q    <= sw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        ch_d    = ch_q;
        rst_d   = rst_q;
        tmo_d   = tmo_q;
        sw_d    = sw_q;
        if (abort) begin
            state_d = ST_WAIT;
            wait_d  = '0;
            gap_d   = '0;
            ch_d    = '0;
            rst_d   = '0;
            sw_d    = '0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (!irst) begin
                        state_d = ST_WAIT;
                        wait_d  = '0;
                    end
                end
                ST_WAIT: begin
                    if (lock_ok || wait_hit) begin
                        rst_d[0] = 1'b1;
                        gap_d    = '0;
                        ch_d     = CH_W'(1);
                        tmo_d    = tmo_q | ~lock_ok;
                        state_d  = (NUM_CH == 1) ? ST_RUN : ST_REL;
                    end else begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end
                ST_REL: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        ch_d  = ch_q + CH_W'(1);
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_q == CH_W'(k)) rst_d[k] = 1'b1;
                        end
                        if (ch_q == CH_LAST) state_d = ST_RUN;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (sw_rst_req[k]) begin
                            sw_d[k]  = SW_LOAD;
                            rst_d[k] = 1'b0;
                        end else if (sw_q[k] != '0) begin
                            sw_d[k] = sw_q[k] - SW_W'(1);
                            if (sw_q[k] == SW_W'(1)) rst_d[k] = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_q <= '0;
        end else if (!rst_q[0]) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DCNT_W'(1);
        end
    end

    assign rst_out_n   = rst_q;
    assign seq_state   = state_q;
    assign seq_done    = (state_q == ST_RUN);
    assign pll_timeout = tmo_q;
    assign clk_div_out = div_q[div_sel];

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed scoreboard bench for rst_seq_gen: timeout-only and
// lock-based instances driven from the same stimulus.
module tb_rst_seq_gen;

    localparam int SIG_RST  = 0;
    localparam int SIG_ST   = 1;
    localparam int SIG_DONE = 2;
    localparam int SIG_TMO  = 3;
    localparam int SIG_DIV  = 4;

    logic       sys_clk    = 1'b0;
    logic       sys_rst    = 1'b1;
    logic       pll_lock   = 1'b0;
    logic [2:0] sw_rst_req = 3'b000;
    logic [2:0] div_sel    = 3'd1;

    logic [2:0] rst0_n, rst1_n;
    logic [1:0] st0, st1;
    logic       done0, done1, tmo0, tmo1, div0, div1;

    always #5 sys_clk = ~sys_clk;

    rst_seq_gen #(
        .NUM_CH(3), .CNT_W(20), .PLL_WAIT(10), .USE_LOCK(0),
        .STAGE_GAP(4), .SW_RST_CYC(5), .DIV_W(3)
    ) u0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pll_lock(pll_lock),
        .sw_rst_req(sw_rst_req), .div_sel(div_sel),
        .rst_out_n(rst0_n), .seq_state(st0), .seq_done(done0),
        .pll_timeout(tmo0), .clk_div_out(div0)
    );

    rst_seq_gen #(
        .NUM_CH(3), .CNT_W(20), .PLL_WAIT(10), .USE_LOCK(1),
        .STAGE_GAP(4), .SW_RST_CYC(5), .DIV_W(3)
    ) u1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pll_lock(pll_lock),
        .sw_rst_req(sw_rst_req), .div_sel(div_sel),
        .rst_out_n(rst1_n), .seq_state(st1), .seq_done(done1),
        .pll_timeout(tmo1), .clk_div_out(div1)
    );

    typedef struct {
        int         at;
        int         dut;
        int         sig;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   edge_no = 0;

    function automatic logic [7:0] observe(int dut, int sig);
        logic [7:0] v;
        v = '0;
        case (sig)
            SIG_RST:  v = {5'd0, (dut != 0) ? rst1_n : rst0_n};
            SIG_ST:   v = {6'd0, (dut != 0) ? st1 : st0};
            SIG_DONE: v = {7'd0, (dut != 0) ? done1 : done0};
            SIG_TMO:  v = {7'd0, (dut != 0) ? tmo1 : tmo0};
            default:  v = {7'd0, (dut != 0) ? div1 : div0};
        endcase
        return v;
    endfunction

    task automatic cmp(string tag, logic [7:0] o, logic [7:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic sb_push(int at, int dut, int sig, logic [7:0] v, string tag);
        exp_t e;
        e.at  = at;
        e.dut = dut;
        e.sig = sig;
        e.val = v;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic sb_pop_due();
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at == edge_no) begin
                cmp($sformatf("%s@e%0d", sbq[i].tag, edge_no),
                    observe(sbq[i].dut, sbq[i].sig), sbq[i].val);
                sbq.delete(i);
            end
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        edge_no++;
        #1;
        sb_pop_due();
    endtask

    task automatic run_to(int n);
        while (edge_no < n) tick();
    endtask

    task automatic neg();
        @(negedge sys_clk);
    endtask

    task automatic drain(string ph);
        n_cmp++;
        assert (sbq.size() == 0) else begin
            n_bad++;
            $error("FAIL %s_drain: observed %0d pending expected 0", ph, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic check_reset_vals(string ph, int dut);
        cmp({ph, "_rst"},  observe(dut, SIG_RST),  8'h00);
        cmp({ph, "_st"},   observe(dut, SIG_ST),   8'h00);
        cmp({ph, "_done"}, observe(dut, SIG_DONE), 8'h00);
        cmp({ph, "_tmo"},  observe(dut, SIG_TMO),  8'h00);
        cmp({ph, "_div"},  observe(dut, SIG_DIV),  8'h00);
    endtask

    task automatic release_rst();
        neg();
        sys_rst = 1'b0;
        edge_no = 0;
    endtask

    task automatic assert_rst();
        neg();
        sys_rst = 1'b1;
        #1;
    endtask

    initial begin
        // Phase A: power-on, timeout path on both instances.
        repeat (3) neg();
        check_reset_vals("por_u0", 0);
        check_reset_vals("por_u1", 1);

        sb_push(2,  0, SIG_ST,   8'd0, "A_st_sync");
        sb_push(3,  0, SIG_ST,   8'd1, "A_st_wait");
        sb_push(12, 0, SIG_RST,  8'h0, "A_rst_pre");
        sb_push(12, 0, SIG_TMO,  8'd0, "A_tmo_pre");
        sb_push(13, 0, SIG_RST,  8'h1, "A_rst_ch0");
        sb_push(13, 0, SIG_ST,   8'd2, "A_st_rel");
        sb_push(13, 0, SIG_TMO,  8'd1, "A_tmo_set");
        sb_push(13, 1, SIG_TMO,  8'd1, "A_u1_tmo");
        sb_push(13, 1, SIG_RST,  8'h1, "A_u1_rst");
        for (int e = 14; e <= 19; e++)
            sb_push(e, 0, SIG_DIV, 8'(((e - 13) >> 1) & 1), "A_div");
        sb_push(16, 0, SIG_RST,  8'h1, "A_rst_hold1");
        sb_push(17, 0, SIG_RST,  8'h3, "A_rst_ch1");
        sb_push(20, 0, SIG_RST,  8'h3, "A_rst_hold2");
        sb_push(20, 0, SIG_DONE, 8'd0, "A_done_pre");
        sb_push(21, 0, SIG_RST,  8'h7, "A_rst_ch2");
        sb_push(21, 0, SIG_ST,   8'd3, "A_st_run");
        sb_push(21, 0, SIG_DONE, 8'd1, "A_done");
        sb_push(21, 0, SIG_TMO,  8'd1, "A_tmo_sticky");
        sb_push(21, 1, SIG_RST,  8'h7, "A_u1_run_rst");
        sb_push(21, 1, SIG_ST,   8'd3, "A_u1_run_st");
        sb_push(28, 1, SIG_RST,  8'h7, "A_u1_toggle_rst");
        sb_push(28, 1, SIG_ST,   8'd3, "A_u1_toggle_st");
        sb_push(30, 0, SIG_RST,  8'h5, "A_sw1_on");
        sb_push(30, 1, SIG_RST,  8'h5, "A_u1_sw1_on");
        sb_push(34, 0, SIG_RST,  8'h5, "A_sw1_hold");
        sb_push(35, 0, SIG_RST,  8'h7, "A_sw1_off");
        sb_push(40, 0, SIG_RST,  8'h5, "A_sw2_on");
        sb_push(43, 0, SIG_RST,  8'h5, "A_sw2_retrig");
        sb_push(47, 0, SIG_RST,  8'h5, "A_sw2_hold");
        sb_push(48, 0, SIG_RST,  8'h7, "A_sw2_off");
        sb_push(50, 0, SIG_RST,  8'h2, "A_swm_on");
        sb_push(54, 0, SIG_RST,  8'h2, "A_swm_hold");
        sb_push(55, 0, SIG_RST,  8'h7, "A_swm_off");
        sb_push(58, 0, SIG_RST,  8'h6, "A_sw0_on");

        release_rst();
        run_to(21);
        neg(); pll_lock = 1'b1;
        run_to(24);
        neg(); pll_lock = 1'b0;
        run_to(29);
        neg(); sw_rst_req = 3'b010;
        run_to(30);
        neg(); sw_rst_req = 3'b000;
        run_to(39);
        neg(); sw_rst_req = 3'b010;
        run_to(40);
        neg(); sw_rst_req = 3'b000;
        run_to(42);
        neg(); sw_rst_req = 3'b010;
        run_to(43);
        neg(); sw_rst_req = 3'b000;
        run_to(49);
        neg(); sw_rst_req = 3'b101;
        run_to(50);
        neg(); sw_rst_req = 3'b000;
        run_to(57);
        neg(); sw_rst_req = 3'b001;
        run_to(58);
        drain("A");
        assert_rst();
        sw_rst_req = 3'b000;
        check_reset_vals("A_midpulse_u0", 0);
        cmp("A_midpulse_u1_rst", observe(1, SIG_RST), 8'h0);
        cmp("A_midpulse_u1_tmo", observe(1, SIG_TMO), 8'h0);

        // Phase B: lock-based release aborted by sys_rst mid-RELEASE.
        repeat (2) neg();
        sb_push(8, 1, SIG_RST, 8'h1, "B_u1_sw_ignored");
        sb_push(8, 1, SIG_ST,  8'd2, "B_u1_rel");
        sb_push(8, 0, SIG_RST, 8'h0, "B_u0_rst");
        sb_push(8, 0, SIG_ST,  8'd1, "B_u0_wait");
        sb_push(9, 1, SIG_DIV, 8'd1, "B_u1_div");
        release_rst();
        run_to(4);
        neg(); pll_lock = 1'b1;
        run_to(7);
        neg(); sw_rst_req = 3'b001;
        run_to(8);
        neg(); sw_rst_req = 3'b000;
        run_to(9);
        drain("B");
        assert_rst();
        check_reset_vals("B_midrel_u1", 1);
        repeat (2) neg();
        pll_lock = 1'b0;

        // Phase C: lock release, lock loss, relock, divider select.
        sb_push(6,  1, SIG_ST,   8'd1, "C_st_wait");
        sb_push(6,  1, SIG_RST,  8'h0, "C_rst_pre");
        sb_push(7,  1, SIG_ST,   8'd2, "C_st_rel");
        sb_push(7,  1, SIG_RST,  8'h1, "C_rst_ch0");
        sb_push(7,  1, SIG_TMO,  8'd0, "C_tmo_clr");
        for (int e = 8; e <= 13; e++)
            sb_push(e, 1, SIG_DIV, 8'(((e - 7) >> 1) & 1), "C_div");
        sb_push(10, 1, SIG_RST,  8'h1, "C_rst_hold1");
        sb_push(11, 1, SIG_RST,  8'h3, "C_rst_ch1");
        sb_push(13, 0, SIG_TMO,  8'd1, "C_u0_tmo");
        sb_push(14, 1, SIG_ST,   8'd2, "C_st_prerun");
        sb_push(15, 1, SIG_ST,   8'd3, "C_st_run");
        sb_push(15, 1, SIG_RST,  8'h7, "C_rst_ch2");
        sb_push(15, 1, SIG_DONE, 8'd1, "C_done");
        sb_push(15, 1, SIG_TMO,  8'd0, "C_tmo_lock");
        sb_push(20, 1, SIG_RST,  8'h7, "C_loss_e0");
        sb_push(21, 1, SIG_ST,   8'd3, "C_loss_e1");
        sb_push(22, 1, SIG_RST,  8'h0, "C_loss_rst");
        sb_push(22, 1, SIG_ST,   8'd1, "C_loss_st");
        sb_push(22, 1, SIG_DONE, 8'd0, "C_loss_done");
        sb_push(24, 1, SIG_DIV,  8'd0, "C_loss_div");
        sb_push(22, 0, SIG_RST,  8'h5, "C_u0_sw");
        sb_push(22, 0, SIG_ST,   8'd3, "C_u0_run");
        sb_push(27, 0, SIG_RST,  8'h7, "C_u0_sw_off");
        sb_push(26, 1, SIG_ST,   8'd1, "C_relock_wait");
        sb_push(27, 1, SIG_RST,  8'h1, "C_relock_ch0");
        sb_push(27, 1, SIG_ST,   8'd2, "C_relock_rel");
        sb_push(31, 1, SIG_RST,  8'h3, "C_relock_ch1");
        sb_push(34, 1, SIG_ST,   8'd2, "C_relock_prerun");
        sb_push(35, 1, SIG_RST,  8'h7, "C_relock_ch2");
        sb_push(35, 1, SIG_DONE, 8'd1, "C_relock_done");
        sb_push(35, 1, SIG_TMO,  8'd0, "C_relock_tmo");
        sb_push(36, 1, SIG_DIV,  8'd0, "C_div_sel1");
        release_rst();
        run_to(4);
        neg(); pll_lock = 1'b1;
        run_to(19);
        neg(); pll_lock = 1'b0;
        run_to(21);
        neg(); sw_rst_req = 3'b010;
        run_to(22);
        neg(); sw_rst_req = 3'b000;
        run_to(24);
        neg(); pll_lock = 1'b1;
        run_to(36);
        neg(); div_sel = 3'd0;
        #1;
        cmp("C_div_sel0_now", observe(1, SIG_DIV), 8'd1);
        sb_push(37, 1, SIG_DIV, 8'd0, "C_div_sel0");
        sb_push(38, 1, SIG_DIV, 8'd1, "C_div_sel0");
        run_to(38);
        drain("C");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
